// File: rtl/if_bus_fetch_pkg.sv
// rtl/if_bus_fetch_pkg.sv - shared types and constants for the instruction-fetch bus master
package if_bus_fetch_pkg;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_BUSY  = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_t;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] NOP_INST  = 32'h0000_0000;

  // Exception word bit positions: ITLB miss arrives from the PC stage,
  // instruction bus error is raised here on an ack timeout.
  localparam int EXC_ITLB_BIT = 13;
  localparam int EXC_IBE_BIT  = 12;

  localparam logic [31:0] ITLB_WORD = 32'h1 << EXC_ITLB_BIT;
  localparam logic [31:0] IBE_WORD  = 32'h1 << EXC_IBE_BIT;

endpackage

// File: rtl/if_bus_fetch.sv
// rtl/if_bus_fetch.sv - instruction-fetch Wishbone read master between the PC register and IF/ID
// Optional feature macro: IF_BUS_TIMEOUT_EN (ack timeout raising instruction bus error)
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   pc_i, ce_i           fetch address and fetch enable from the PC register
//   excepttype_i         exception word from the PC register (bit13 = ITLB miss)
//   stall_i, flush_i     ctrl stall vector (bit1 = IF/ID held) and pipeline flush
//   wb_*                 Wishbone-style read master port
//   inst_o, excepttype_o instruction and exception word to IF/ID
//   stallreq_o           stall request to ctrl while a fetch is outstanding
module if_bus_fetch
  import if_bus_fetch_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic [31:0]       excepttype_i,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [31:0]       excepttype_o,
  output logic              stallreq_o
);

  if_state_t         state, state_next;
  logic [DATA_W-1:0] rd_buf;
  logic              start;
  logic              ld_buf;
  logic              tmo_hit;
  logic [DATA_W-1:0] inst_c;
  logic [31:0]       exc_c;
  logic              stall_c;

  // Only the IF/ID hold bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

`ifdef IF_BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC)) && !wb_ack_i;

  // Counts consecutive cycles spent in one waiting state; any state change
  // (ack, timeout, BUSY->DRAIN) restarts it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if ((state == IF_BUSY || state == IF_DRAIN) && state_next == state) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYC);
  assign tmo_hit    = 1'b0;
`endif

  assign start = (state == IF_IDLE) && ce_i && !flush_i && (excepttype_i == ZERO_WORD);

  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    inst_c     = DATA_W'(NOP_INST);
    exc_c      = ZERO_WORD;
    ld_buf     = 1'b0;
    case (state)
      IF_IDLE: begin
        stall_c = start;
        if (start) begin
          state_next = IF_BUSY;
        end
        // A translation exception is forwarded without touching the bus.
        if (excepttype_i != ZERO_WORD) begin
          exc_c = excepttype_i;
        end
      end
      IF_BUSY: begin
        if (wb_ack_i && !flush_i) begin
          // Data goes straight to IF/ID in the ack cycle; the copy in rd_buf
          // is only needed if IF/ID is held this cycle.
          inst_c     = wb_dat_i;
          ld_buf     = 1'b1;
          state_next = stall_i[1] ? IF_HOLD : IF_IDLE;
        end else if (flush_i) begin
          // A transfer cannot be aborted mid-flight: keep cyc until ack.
          state_next = (wb_ack_i || tmo_hit) ? IF_IDLE : IF_DRAIN;
        end else if (tmo_hit) begin
          exc_c      = IBE_WORD;
          state_next = IF_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      IF_HOLD: begin
        if (!flush_i) begin
          inst_c = rd_buf;
        end
        if (!stall_i[1] || flush_i) begin
          state_next = IF_IDLE;
        end
      end
      IF_DRAIN: begin
        stall_c = !tmo_hit;
        if (wb_ack_i || tmo_hit) begin
          state_next = IF_IDLE;
        end
      end
      default: begin
        state_next = IF_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IF_IDLE;
      wb_cyc_o <= 1'b0;
      wb_adr_o <= '0;
      rd_buf   <= '0;
    end else begin
      state    <= state_next;
      wb_cyc_o <= (state_next == IF_BUSY) || (state_next == IF_DRAIN);
      if (start) begin
        wb_adr_o <= pc_i;
      end
      if (ld_buf) begin
        rd_buf <= wb_dat_i;
      end
    end
  end

  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = wb_cyc_o ? 4'b1111 : 4'b0000;

  // IF/ID sees a quiet interface while reset is asserted.
  assign inst_o       = rst ? inst_c  : DATA_W'(NOP_INST);
  assign excepttype_o = rst ? exc_c   : ZERO_WORD;
  assign stallreq_o   = rst ? stall_c : 1'b0;

endmodule

// File: tb/tb_if_bus_fetch.sv
// tb/tb_if_bus_fetch.sv - scoreboard bench for the instruction-fetch bus master
module tb_if_bus_fetch;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [31:0] excepttype_i;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic [31:0] inst_o;
  logic [31:0] excepttype_o;
  logic        stallreq_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] inst;
    logic        stall;
    logic [31:0] exc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  if_bus_fetch #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .excepttype_i(excepttype_i),
    .stall_i(stall_i), .flush_i(flush_i), .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .inst_o(inst_o), .excepttype_o(excepttype_o), .stallreq_o(stallreq_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed bus beat is matched against the next expectation.
  always @(negedge clk) begin
    if (rst && wb_cyc_o && wb_ack_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_inst", inst_o, e.inst);
        chk("sb_stallreq", {31'd0, stallreq_o}, {31'd0, e.stall});
        chk("sb_exc", excepttype_o, e.exc);
      end
    end
  end

  // Issue one fetch with a given number of wait states; leaves the bench just
  // after the edge that closes the ack cycle.
  task automatic fetch(input logic [31:0] pc, input int waits, input logic [31:0] data,
                       input logic hold);
    exp_t e;
    ce_i = 1'b1;
    pc_i = pc;
    @(negedge clk);
    chk("start_stallreq", {31'd0, stallreq_o}, 32'd1);
    chk("start_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
    tick();
    ce_i = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("wait_cyc", {31'd0, wb_cyc_o}, 32'd1);
      chk("wait_stallreq", {31'd0, stallreq_o}, 32'd1);
      chk("wait_inst", inst_o, 32'h0);
      tick();
    end
    e.inst = data; e.stall = 1'b0; e.exc = 32'h0;
    exp_q.push_back(e);
    wb_ack_i = 1'b1;
    wb_dat_i = data;
    stall_i[1] = hold;
    @(negedge clk);
    chk("adr", wb_adr_o, pc);
    chk("sel", {28'd0, wb_sel_o}, 32'hF);
    chk("stb", {31'd0, wb_stb_o}, 32'd1);
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
  endtask

  initial begin
    exp_t e;
    bit seen;
    rst = 1'b0; ce_i = 1'b0; pc_i = 32'h0; excepttype_i = 32'h2000;
    stall_i = 6'd0; flush_i = 1'b0; wb_dat_i = 32'h0; wb_ack_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_exc", excepttype_o, 32'h0);
    chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
    chk("rst_inst", inst_o, 32'h0);
    tick();
    rst = 1'b1; excepttype_i = 32'h0;
    tick();

    // Zero-wait fetch; address held after cyc drops.
    fetch(32'h1000, 0, 32'h1111_2222, 1'b0);
    @(negedge clk);
    chk("t1_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    chk("t1_adr_hold", wb_adr_o, 32'h1000);
    chk("t1_we", {31'd0, wb_we_o}, 32'd0);
    tick();

    // Three wait states.
    fetch(32'h1004, 3, 32'hA5A5_0001, 1'b0);
    @(negedge clk);
    chk("t2_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    chk("t2_inst_after", inst_o, 32'h0);
    tick();

    // IF/ID held at ack: data parked in HOLD, no new bus cycle.
    fetch(32'h2000, 0, 32'h2402_0005, 1'b1);
    ce_i = 1'b1; pc_i = 32'h2004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_inst", inst_o, 32'h2402_0005);
      chk("t3_hold_cyc", {31'd0, wb_cyc_o}, 32'd0);
      chk("t3_hold_stallreq", {31'd0, stallreq_o}, 32'd0);
      tick();
    end
    ce_i = 1'b0; stall_i[1] = 1'b0;
    tick();
    @(negedge clk);
    chk("t3_release_inst", inst_o, 32'h0);
    chk("t3_release_cyc", {31'd0, wb_cyc_o}, 32'd0);
    tick();

    // Flush before ack: drain the transfer and discard its data.
    ce_i = 1'b1; pc_i = 32'h3000;
    tick();
    ce_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    chk("t4_flush_stallreq", {31'd0, stallreq_o}, 32'd0);
    chk("t4_flush_inst", inst_o, 32'h0);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    chk("t4_drain_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("t4_drain_stallreq", {31'd0, stallreq_o}, 32'd1);
    tick();
    e.inst = 32'h0; e.stall = 1'b1; e.exc = 32'h0;
    exp_q.push_back(e);
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    @(negedge clk);
    chk("t4_drain_done_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("t4_drain_done_inst", inst_o, 32'h0);
    tick();

    // Flush coinciding with ack in BUSY.
    ce_i = 1'b1; pc_i = 32'h3100;
    tick();
    ce_i = 1'b0; flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    e.inst = 32'h0; e.stall = 1'b0; e.exc = 32'h0;
    exp_q.push_back(e);
    tick();
    flush_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    @(negedge clk);
    chk("t4b_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    tick();

    // ITLB miss: forwarded, no bus access.
    ce_i = 1'b1; pc_i = 32'h5000; excepttype_i = 32'h0000_2000;
    @(negedge clk);
    chk("t5_exc", excepttype_o, 32'h0000_2000);
    chk("t5_inst", inst_o, 32'h0);
    chk("t5_stallreq", {31'd0, stallreq_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("t5_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
    ce_i = 1'b0; excepttype_i = 32'h0;
    tick();

    // Reset in the middle of a transfer.
    ce_i = 1'b1; pc_i = 32'h4000;
    tick();
    ce_i = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy_stallreq", {31'd0, stallreq_o}, 32'd0);
    chk("t6_rst_busy_cyc_still", {31'd0, wb_cyc_o}, 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_after_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("t6_after_rst_adr", wb_adr_o, 32'h0);
    chk("t6_after_rst_stallreq", {31'd0, stallreq_o}, 32'd0);
    tick();

`ifdef IF_BUS_TIMEOUT_EN
    // Ack never arrives: bus error after the timeout window.
    ce_i = 1'b1; pc_i = 32'h6000;
    tick();
    ce_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < TMO + 10 && !seen; i++) begin
      @(negedge clk);
      if (excepttype_o[12]) begin
        seen = 1'b1;
        chk("tmo_cycle", i, TMO);
        chk("tmo_inst", inst_o, 32'h0);
        chk("tmo_stallreq", {31'd0, stallreq_o}, 32'd0);
      end
      tick();
    end
    chk("tmo_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("tmo_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    tick();
`else
    seen = 1'b1;
`endif

    repeat (2) tick();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
